// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    localparam int ADDR_STEP = 4;

    // One-hot status word driving the busy/done/err pins.
    typedef struct packed {
        logic busy;
        logic done;
        logic err;
    } status_t;

    localparam status_t STAT_IDLE = '{busy: 1'b0, done: 1'b0, err: 1'b0};
    localparam status_t STAT_BUSY = '{busy: 1'b1, done: 1'b0, err: 1'b0};
    localparam status_t STAT_DONE = '{busy: 1'b0, done: 1'b1, err: 1'b0};
    localparam status_t STAT_ERR  = '{busy: 1'b0, done: 1'b0, err: 1'b1};

endpackage

// File: rtl/imem_loader_if.sv
// Word-stream and instruction-memory bus of the loader; master is the loader side.
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic              imem_re;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        input  s_valid, s_data, imem_rdata,
        output s_ready, imem_we, imem_re, imem_addr, imem_wdata
    );

    modport slave (
        output s_valid, s_data, imem_rdata,
        input  s_ready, imem_we, imem_re, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_sum.sv
// Clearable modulo-2^DATA_W accumulator; clear has priority over accumulate.
module imem_loader_sum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_r;

    // Running sum register, wraps naturally at DATA_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (en) begin
            sum_r <= sum_r + din;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, reads it back, checks the sum,
// and releases the CPU only after a verified load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    state_e            state_r;
    status_t           status_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  idx_r;
    logic              s_ready_r;
    logic              we_r;
    logic              re_r;
    logic              re_last_r;
    logic              rd_pend_r;
    logic              rd_last_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              hold_r;
    logic [DATA_W-1:0] checksum_r;

    logic              start_acc_s;
    logic              hs_s;
    logic              rd_acc_s;
    logic [ADDR_W:0]   range_end_s;
    logic              range_bad_s;
    logic [DATA_W-1:0] wsum_s;
    logic [DATA_W-1:0] rsum_s;
    logic [DATA_W-1:0] rsum_final_s;

    assign start_acc_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
    assign hs_s         = (state_r == S_LOAD) && s_ready_r && bus.s_valid && !abort;
    assign rd_acc_s     = (state_r == S_VERIFY) && rd_pend_r;
    // One extra bit so the word-index end cannot overflow before the compare.
    assign range_end_s  = (ADDR_W+1)'(base_addr >> 2) + (ADDR_W+1)'(count);
    assign range_bad_s  = range_end_s > (ADDR_W+1)'(DEPTH);
    assign rsum_final_s = rsum_s + bus.imem_rdata;

    imem_loader_sum #(.DATA_W(DATA_W)) u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (start_acc_s),
        .en  (hs_s),
        .din (bus.s_data),
        .sum (wsum_s)
    );

    imem_loader_sum #(.DATA_W(DATA_W)) u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (start_acc_s),
        .en  (rd_acc_s),
        .din (bus.imem_rdata),
        .sum (rsum_s)
    );

    // Load/verify sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            status_r    <= STAT_IDLE;
            base_r      <= {ADDR_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= {CNT_W{1'b0}};
            s_ready_r   <= 1'b0;
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            re_last_r   <= 1'b0;
            rd_pend_r   <= 1'b0;
            rd_last_r   <= 1'b0;
            imem_addr_r <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            hold_r      <= 1'b1;
            checksum_r  <= {DATA_W{1'b0}};
        end else begin
            we_r      <= 1'b0;
            re_r      <= 1'b0;
            re_last_r <= 1'b0;
            // Read data returns one cycle after the strobe; track it alongside.
            rd_pend_r <= re_r;
            rd_last_r <= re_last_r;
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        base_r <= {base_addr[ADDR_W-1:2], 2'b00};
                        addr_r <= {base_addr[ADDR_W-1:2], 2'b00};
                        cnt_r  <= count;
                        idx_r  <= {CNT_W{1'b0}};
                        hold_r <= 1'b1;
                        if (range_bad_s) begin
                            state_r  <= S_ERR;
                            status_r <= STAT_ERR;
                        end else if (count == CNT_W'(0)) begin
                            state_r    <= S_DONE;
                            status_r   <= STAT_DONE;
                            hold_r     <= 1'b0;
                            checksum_r <= {DATA_W{1'b0}};
                        end else begin
                            state_r   <= S_LOAD;
                            status_r  <= STAT_BUSY;
                            s_ready_r <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_r   <= S_IDLE;
                        status_r  <= STAT_IDLE;
                        s_ready_r <= 1'b0;
                        hold_r    <= 1'b1;
                    end else if (hs_s) begin
                        we_r        <= 1'b1;
                        imem_addr_r <= addr_r;
                        wdata_r     <= bus.s_data;
                        addr_r      <= addr_r + ADDR_W'(ADDR_STEP);
                        idx_r       <= idx_r + CNT_W'(1);
                        if (idx_r == cnt_r - CNT_W'(1)) begin
                            state_r   <= S_VERIFY;
                            s_ready_r <= 1'b0;
                            idx_r     <= {CNT_W{1'b0}};
                            addr_r    <= base_r;
                        end
                    end
                end
                S_VERIFY: begin
                    if (abort) begin
                        state_r  <= S_IDLE;
                        status_r <= STAT_IDLE;
                        hold_r   <= 1'b1;
                    end else begin
                        // Reads start one cycle in, after the final write has landed.
                        if (idx_r != cnt_r) begin
                            re_r        <= 1'b1;
                            re_last_r   <= (idx_r == cnt_r - CNT_W'(1));
                            imem_addr_r <= addr_r;
                            addr_r      <= addr_r + ADDR_W'(ADDR_STEP);
                            idx_r       <= idx_r + CNT_W'(1);
                        end
                        if (rd_pend_r && rd_last_r) begin
                            if (rsum_final_s == wsum_s) begin
                                state_r    <= S_DONE;
                                status_r   <= STAT_DONE;
                                hold_r     <= 1'b0;
                                checksum_r <= wsum_s;
                            end else begin
                                state_r  <= S_ERR;
                                status_r <= STAT_ERR;
                                hold_r   <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    status_r  <= STAT_IDLE;
                    s_ready_r <= 1'b0;
                    hold_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s_ready    = s_ready_r;
    assign bus.imem_we    = we_r;
    assign bus.imem_re    = re_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = wdata_r;
    assign cpu_hold       = hold_r;
    assign busy           = status_r.busy;
    assign done           = status_r.done;
    assign err            = status_r.err;
    assign checksum       = checksum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: synchronous memory model plus per-scenario tasks.
module tb_imem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = 9;
    localparam logic [31:0] EXP_SUM = 32'hB4B8_10DF;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              cpu_hold, busy, done, err;
    logic [DATA_W-1:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [11] = '{32'h2008_0005, 32'h2009_000C, 32'h0109_5020, 32'h0109_5822,
                               32'hAC0A_0030, 32'h8C0B_0030, 32'h116A_0001, 32'h200C_0001,
                               32'h0109_682A, 32'h0800_0000, 32'h0000_0000};

    imem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .count     (count),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with traffic logs and an optional readback fault at byte 12.
    logic [31:0] mem [DEPTH];
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [31:0] rd_addr_log [64];
    int          wr_total   = 0;
    int          rd_total   = 0;
    logic        corrupt_en = 1'b0;

    always @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_addr[9:2]]   <= bus.imem_wdata;
            wr_addr_log[wr_total % 64] <= bus.imem_addr;
            wr_data_log[wr_total % 64] <= bus.imem_wdata;
            wr_total                   <= wr_total + 1;
        end
        if (bus.imem_re) begin
            bus.imem_rdata <= mem[bus.imem_addr[9:2]] ^
                              ((corrupt_en && bus.imem_addr == 32'd12) ? 32'h0000_0100 : 32'h0000_0000);
            rd_addr_log[rd_total % 64] <= bus.imem_addr;
            rd_total                   <= rd_total + 1;
        end
    end

    // Start a load and stream words; returns edges-after-start at which done/err was seen (-1 if not).
    task automatic do_load(input logic [31:0] b, input logic [CNT_W-1:0] n, input bit stall,
                           input int abort_hs, input int max_cyc,
                           output int delta, output int hs_n, output bit hold_lo);
        int k;
        bit hs;
        bit aborted;
        k = 0; hs_n = 0; delta = -1; hold_lo = 1'b0; aborted = 1'b0;
        base_addr = b; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            abort = 1'b0;
            bus.s_valid = 1'b0;
            if (abort_hs >= 0 && hs_n == abort_hs) begin
                abort = 1'b1;
                aborted = 1'b1;
            end else if (bus.s_ready && hs_n < int'(n)) begin
                bus.s_valid = !stall || (k % 2 == 1);
                bus.s_data  = prog[hs_n % 11];
            end
            hs = bus.s_valid && bus.s_ready;
            if (bus.s_ready) k++;
            @(posedge clk); #1;
            if (hs) hs_n++;
            if (!done && !cpu_hold) hold_lo = 1'b1;
            if (aborted) break;
            if (done || err) begin
                delta = c;
                break;
            end
        end
        abort = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cpu_hold, busy, done, err, bus.s_ready, bus.imem_we, bus.imem_re} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b",
                     {cpu_hold, busy, done, err, bus.s_ready, bus.imem_we, bus.imem_re}, 7'b1000000);
        end
        n_checks++;
        if (checksum !== 32'h0 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: checksum %h addr %h expected 0 0", checksum, bus.imem_addr);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({cpu_hold, busy, done, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_flags: got %b expected %b", {cpu_hold, busy, done, err}, 4'b1000);
        end
    endtask

    task automatic check_full_load(input string name, input int delta, input int exp_delta,
                                   input int hs, input bit hold_lo, input int w0, input int r0);
        n_checks++;
        if (delta !== exp_delta) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, delta, exp_delta);
        end
        n_checks++;
        if ({done, err, cpu_hold, busy} !== 4'b1000 || hold_lo !== 1'b0 || hs !== 11) begin
            n_fail++;
            $display("FAIL %s_status: flags %b hold_lo %b hs %0d expected 1000 0 11",
                     name, {done, err, cpu_hold, busy}, hold_lo, hs);
        end
        n_checks++;
        if (checksum !== EXP_SUM) begin
            n_fail++;
            $display("FAIL %s_checksum: got %h expected %h", name, checksum, EXP_SUM);
        end
        n_checks++;
        if (wr_total - w0 !== 11 || rd_total - r0 !== 11) begin
            n_fail++;
            $display("FAIL %s_traffic: writes %0d reads %0d expected 11 11", name, wr_total - w0, rd_total - r0);
        end
        for (int j = 0; j < 11; j++) begin
            n_checks++;
            if (wr_addr_log[(w0 + j) % 64] !== 32'(4 * j) || wr_data_log[(w0 + j) % 64] !== prog[j] ||
                rd_addr_log[(r0 + j) % 64] !== 32'(4 * j) || mem[j] !== prog[j]) begin
                n_fail++;
                $display("FAIL %s_word%0d: waddr %h wdata %h raddr %h mem %h expected addr %h data %h",
                         name, j, wr_addr_log[(w0 + j) % 64], wr_data_log[(w0 + j) % 64],
                         rd_addr_log[(r0 + j) % 64], mem[j], 32'(4 * j), prog[j]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d, hs, w0, r0;
        bit hl;
        w0 = wr_total; r0 = rd_total;
        do_load(32'h0, 9'd11, 1'b0, -1, 200, d, hs, hl);
        check_full_load("b2b", d, 24, hs, hl, w0, r0);
    endtask

    task automatic test_stall;
        int d, hs, w0, r0;
        bit hl;
        w0 = wr_total; r0 = rd_total;
        do_load(32'h0, 9'd11, 1'b1, -1, 200, d, hs, hl);
        check_full_load("stall", d, 35, hs, hl, w0, r0);
    endtask

    task automatic test_corrupt;
        int d, hs;
        bit hl;
        corrupt_en = 1'b1;
        do_load(32'h0, 9'd11, 1'b0, -1, 200, d, hs, hl);
        corrupt_en = 1'b0;
        n_checks++;
        if (d !== 24 || {done, err, cpu_hold, busy} !== 4'b0110 || hl !== 1'b0) begin
            n_fail++;
            $display("FAIL corrupt: latency %0d flags %b hold_lo %b expected 24 0110 0",
                     d, {done, err, cpu_hold, busy}, hl);
        end
    endtask

    task automatic test_range_err;
        int d, hs, w0, r0;
        bit hl;
        w0 = wr_total; r0 = rd_total;
        do_load(32'(4 * (DEPTH - 2)), 9'd3, 1'b0, -1, 50, d, hs, hl);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (d !== 1 || {done, err, cpu_hold, busy} !== 4'b0110) begin
            n_fail++;
            $display("FAIL range_err: latency %0d flags %b expected 1 0110", d, {done, err, cpu_hold, busy});
        end
        n_checks++;
        if (wr_total - w0 !== 0 || rd_total - r0 !== 0) begin
            n_fail++;
            $display("FAIL range_traffic: writes %0d reads %0d expected 0 0", wr_total - w0, rd_total - r0);
        end
    endtask

    task automatic test_abort;
        int d, hs, w0, r0;
        bit hl;
        w0 = wr_total; r0 = rd_total;
        do_load(32'h0, 9'd11, 1'b0, 3, 50, d, hs, hl);
        n_checks++;
        if (hs !== 3 || {done, err, cpu_hold, busy, bus.s_ready} !== 5'b00100) begin
            n_fail++;
            $display("FAIL abort_state: hs %0d flags %b expected 3 00100", hs, {done, err, cpu_hold, busy, bus.s_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wr_total - w0 !== 3 || rd_total - r0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_traffic: writes %0d reads %0d busy %b expected 3 0 0",
                     wr_total - w0, rd_total - r0, busy);
        end
    endtask

    task automatic test_rst_mid_verify;
        int d, hs, w0, r0;
        bit hl;
        do_load(32'h0, 9'd11, 1'b0, -1, 15, d, hs, hl);
        n_checks++;
        if (busy !== 1'b1 || d !== -1) begin
            n_fail++;
            $display("FAIL verify_busy: busy %b latency %0d expected 1 -1", busy, d);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cpu_hold, busy, done, err, bus.s_ready, bus.imem_we, bus.imem_re} !== 7'b1000000 ||
            checksum !== 32'h0 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: flags %b checksum %h addr %h expected 1000000 0 0",
                     {cpu_hold, busy, done, err, bus.s_ready, bus.imem_we, bus.imem_re}, checksum, bus.imem_addr);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        w0 = wr_total; r0 = rd_total;
        do_load(32'h0, 9'd11, 1'b0, -1, 200, d, hs, hl);
        check_full_load("restart", d, 24, hs, hl, w0, r0);
    endtask

    task automatic test_zero_count;
        int d, hs, w0, r0;
        bit hl;
        w0 = wr_total; r0 = rd_total;
        do_load(32'h40, 9'd0, 1'b0, -1, 50, d, hs, hl);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (d !== 1 || {done, err, cpu_hold, busy} !== 4'b1000 || checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_count: latency %0d flags %b checksum %h expected 1 1000 0",
                     d, {done, err, cpu_hold, busy}, checksum);
        end
        n_checks++;
        if (wr_total - w0 !== 0 || rd_total - r0 !== 0) begin
            n_fail++;
            $display("FAIL zero_traffic: writes %0d reads %0d expected 0 0", wr_total - w0, rd_total - r0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_corrupt();
        test_range_err();
        test_abort();
        test_rst_mid_verify();
        test_zero_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction-memory loader for the single-cycle MIPS core. It accepts a word stream over a valid/ready handshake and writes it to consecutive word addresses of instruction memory. It then reads the region back and compares a modulo-2^DATA_W checksum. The CPU is held in reset until a load verifies. It replaces per-cycle address/data poking with a bounded, checked burst.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 32, byte-address width
- DEPTH, 256, instruction memory size in words; CNT_W = clog2(DEPTH+1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin load; sampled only in IDLE, DONE, ERR
- abort  in  1  cancel; honoured only in LOAD and VERIFY
- base_addr  in  ADDR_W  byte address of first word; bits [1:0] forced to 0
- count  in  CNT_W  number of words to load
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  loader accepts a word; equals (state==LOAD)
- imem_we  out  1  instruction memory write strobe
- imem_re  out  1  instruction memory read strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  DATA_W  write data
- imem_rdata  in  DATA_W  read data, valid one cycle after imem_re
- cpu_hold  out  1  CPU reset request, high = hold
- busy, done, err  out  1  status
- checksum  out  DATA_W  sum of words accepted in the last load

## Operation
- States: IDLE, LOAD, VERIFY, DONE, ERR.
- Reset (asynchronous, immediate, any state) puts the FSM in IDLE and sets all outputs to 0 except cpu_hold=1.
- IDLE/DONE/ERR with start=1: latch base and count, clear sums, set cpu_hold=1.
  - Go to ERR if (base_addr/4)+count > DEPTH.
  - Else go to DONE if count==0 (checksum=0).
  - Else go to LOAD.
- LOAD: s_ready=1. Each handshake (s_valid&s_ready) with index i registers imem_we=1, imem_addr=base+4*i and imem_wdata=s_data for the next cycle. It also adds s_data to wsum, modulo 2^DATA_W. The count-th handshake moves to VERIFY.
- VERIFY:
  - First cycle: the final write only, no read.
  - Next count cycles: imem_re=1 at base+4*j, j=0..count-1.
  - rsum accumulates imem_rdata one cycle after each read.
  - After the last read data arrives: rsum==wsum goes to DONE, otherwise ERR.
- DONE: done=1, cpu_hold=0, checksum=wsum.
- ERR: err=1, cpu_hold=1.
- abort in LOAD or VERIFY: go to IDLE next cycle with cpu_hold=1. Any pending registered write still completes that cycle.
- start in LOAD or VERIFY is ignored.
- busy=1 in LOAD and VERIFY.
- Addresses never wrap: the range check at start guarantees this.

## Timing
- start sampled at edge 0: LOAD (s_ready=1) from cycle 1.
- Handshake at edge k: the imem write is in cycle k+1.
- Best-case load of N words: N cycles in LOAD, then N+1 cycles in VERIFY. done rises at cycle 2N+2 after start.
- Stalls (s_valid=0) extend LOAD one cycle per stall. No word is dropped or duplicated.
- Simultaneous start and abort in IDLE: start wins. In LOAD: abort wins.
- cpu_hold falls on the same edge done rises. It rises on the edge after start is accepted.

## Structure
- Package imem_loader_pkg holds:
  - state enum
  - ADDR_STEP = 4
  - status encoding
- Sub-module imem_loader_sum: clearable modulo-2^DATA_W accumulator. It is instantiated twice, for wsum and rsum.
- The FSM and address counter sit in the top level.

## Test plan
- base=0, count=11, the eleven reference program words streamed back-to-back:
  - writes to 0,4,…,40, reads back the same.
  - done at cycle 24, cpu_hold low.
  - checksum = modular sum.
- Same load with s_valid low every other cycle: identical memory image and checksum; done delayed by 11 cycles.
- Memory model corrupts word at 12 on readback: err=1, done=0, cpu_hold stays 1.
- base=4*(DEPTH-2), count=3: ERR one cycle after start, with no imem_we and no imem_re.
- count=0: DONE next cycle, checksum=0, no memory traffic.
- Two further cases:
  - abort after 3 handshakes: IDLE, cpu_hold=1.
  - rst pulsed low mid-VERIFY: all outputs at reset values immediately; a restart loads correctly.
